// File: rtl/log_systolic_skew_feeder_pkg.sv
// Shared types for the log-compact systolic skew feeder: the sequencing FSM
// encoding and the width of the result-row index.
package log_systolic_skew_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_OUT
  } state_e;

  // A 1-lane grid still needs a 1-bit row index port.
  function automatic int row_idx_w(input int tile);
    return (tile > 1) ? $clog2(tile) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_lane.sv
// One staircase lane: DEPTH registers that shift on advance, hold otherwise,
// and zero on a synchronous clear. The last stage drives the grid input.
module skew_delay_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             advance,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  // NOTE: stage_d starts from stage_q before any branch, so every path assigns it and no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    if (clear) begin
      stage_d = '0;
    end else if (advance) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // NOTE: these are plain flops feeding the grid, so they take the reset; zeros on the lanes are meaningful data.
  // NOTE: non-blocking assignment keeps every stage sampling the pre-edge value of its neighbour.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/log_systolic_skew_feeder.sv
// Front end of the log-compact systolic grid: skews A/B beats into a staircase,
// sequences clear/multiply/drain, then streams result rows out over valid/ready.
module log_systolic_skew_feeder
  import log_systolic_skew_feeder_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TILE         = 32,
  parameter int DRAIN_CYCLES = 2 * TILE + 1
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic [TILE*WIDTH-1:0]        aIn,
  input  logic [TILE*WIDTH-1:0]        bIn,
  input  logic                         inValid,
  input  logic                         inLast,
  output logic                         inReady,
  output logic [TILE*WIDTH-1:0]        aNextOut,
  output logic [TILE*WIDTH-1:0]        bNextOut,
  output logic                         enableMul,
  output logic                         enableShiftOut,
  output logic                         gridClear,
  input  logic [TILE*WIDTH-1:0]        cNextIn,
  output logic [TILE*WIDTH-1:0]        outData,
  output logic [row_idx_w(TILE)-1:0]   outRow,
  output logic                         outValid,
  input  logic                         outReady,
  output logic                         busy
);

  localparam int ROW_W = row_idx_w(TILE);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(TILE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [ROW_W-1:0]     row_idx_q, row_idx_d;
  logic                 enable_mul_q, enable_mul_d;
  logic                 advance;
  logic                 lane_clear;
  logic [TILE*WIDTH-1:0] a_feed, b_feed;

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    row_idx_d      = row_idx_q;
    advance        = 1'b0;
    lane_clear     = 1'b0;
    a_feed         = '0;
    b_feed         = '0;
    inReady        = 1'b0;
    gridClear      = 1'b0;
    outValid       = 1'b0;
    enableShiftOut = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (inValid) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        gridClear  = 1'b1;
        lane_clear = 1'b1;
        state_d    = ST_FEED;
      end
      ST_FEED: begin
        inReady = 1'b1;
        if (inValid) begin
          advance = 1'b1;
          a_feed  = aIn;
          b_feed  = bIn;
          if (inLast) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        // Zero beats flush the staircase; the count-0 cycle lets the last
        // registered enableMul retire before OUT so it never meets enableShiftOut.
        if (drain_cnt_q != '0) begin
          advance     = 1'b1;
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end else begin
          state_d   = ST_OUT;
          row_idx_d = LAST_ROW;
        end
      end
      ST_OUT: begin
        outValid = 1'b1;
        if (outReady) begin
          if (row_idx_q != '0) begin
            enableShiftOut = 1'b1;
            row_idx_d      = row_idx_q - ROW_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enable_mul_d = advance;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      row_idx_q    <= '0;
      enable_mul_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      row_idx_q    <= row_idx_d;
      enable_mul_q <= enable_mul_d;
    end
  end

  for (genvar j = 0; j < TILE; j++) begin : g_lane
    skew_delay_lane #(.WIDTH(WIDTH), .DEPTH(j + 1)) u_a_lane (
      .clock   (clock),
      .resetN  (resetN),
      .advance (advance),
      .clear   (lane_clear),
      .din     (a_feed[j*WIDTH +: WIDTH]),
      .dout    (aNextOut[j*WIDTH +: WIDTH])
    );
    skew_delay_lane #(.WIDTH(WIDTH), .DEPTH(j + 1)) u_b_lane (
      .clock   (clock),
      .resetN  (resetN),
      .advance (advance),
      .clear   (lane_clear),
      .din     (b_feed[j*WIDTH +: WIDTH]),
      .dout    (bNextOut[j*WIDTH +: WIDTH])
    );
  end

  assign enableMul = enable_mul_q;
  assign outData   = outValid ? cNextIn : '0;
  assign outRow    = row_idx_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
